// File: rtl/debug_host.sv
// debug_host: host-side initiator for the UART debug protocol.
// Sends one '+'-prefixed command frame byte by byte, then parses the "OK"/"NO" reply into a status/data word.
module debug_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_address,
  input  logic [31:0] req_value,
  output logic        rsp_valid,
  output logic        rsp_ok,
  output logic        rsp_timeout,
  output logic [31:0] rsp_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_done
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] CMD_HL = 3'd0;
  localparam logic [2:0] CMD_RE = 3'd1;
  localparam logic [2:0] CMD_PC = 3'd2;
  localparam logic [2:0] CMD_ST = 3'd3;
  localparam logic [2:0] CMD_MR = 3'd4;
  localparam logic [2:0] CMD_MW = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_TX, S_RECV, S_DONE} state_e;

  function automatic logic [15:0] cmd_chars(input logic [2:0] cmd);
    logic [15:0] c;
    case (cmd)
      CMD_HL:  c = 16'h484C;
      CMD_RE:  c = 16'h5245;
      CMD_PC:  c = 16'h5043;
      CMD_ST:  c = 16'h5354;
      CMD_MR:  c = 16'h4D52;
      CMD_MW:  c = 16'h4D57;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] frame_len(input logic [2:0] cmd);
    logic [3:0] n;
    case (cmd)
      CMD_MR:  n = 4'd7;
      CMD_MW:  n = 4'd11;
      default: n = 4'd3;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] reply_len(input logic [2:0] cmd);
    logic [2:0] n;
    case (cmd)
      CMD_ST:         n = 3'd3;
      CMD_PC, CMD_MR: n = 3'd6;
      default:        n = 3'd2;
    endcase
    return n;
  endfunction

  // Byte idx of the frame: '+', two command chars, address and value MSB first.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [2:0] cmd,
                                            input logic [31:0] addr, input logic [31:0] val);
    logic [15:0] c;
    logic [7:0]  b;
    c = cmd_chars(cmd);
    case (idx)
      4'd0:    b = 8'h2B;
      4'd1:    b = c[15:8];
      4'd2:    b = c[7:0];
      4'd3:    b = addr[31:24];
      4'd4:    b = addr[23:16];
      4'd5:    b = addr[15:8];
      4'd6:    b = addr[7:0];
      4'd7:    b = val[31:24];
      4'd8:    b = val[23:16];
      4'd9:    b = val[15:8];
      4'd10:   b = val[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      value_q, value_d;
  logic [3:0]       idx_q, idx_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic             ok0_q, ok0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_ok_q, rsp_ok_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [31:0]      rsp_data_q, rsp_data_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cmd_q         <= 3'd0;
      addr_q        <= 32'd0;
      value_q       <= 32'd0;
      idx_q         <= 4'd0;
      rx_idx_q      <= 3'd0;
      ok0_q         <= 1'b0;
      cnt_q         <= '0;
      tx_data_q     <= 8'd0;
      tx_start_q    <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_ok_q      <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      value_q       <= value_d;
      idx_q         <= idx_d;
      rx_idx_q      <= rx_idx_d;
      ok0_q         <= ok0_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    value_d       = value_q;
    idx_d         = idx_q;
    rx_idx_d      = rx_idx_q;
    ok0_d         = ok0_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_ok_d      = rsp_ok_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_data_d    = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          cmd_d         = req_cmd;
          addr_d        = req_address;
          value_d       = req_value;
          idx_d         = 4'd0;
          rx_idx_d      = 3'd0;
          ok0_d         = 1'b0;
          rsp_ok_d      = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_data_d    = 32'd0;
          if (req_cmd > CMD_MW) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
          end else begin
            // The '+' is launched straight from acceptance; later bytes go out one cycle after SEND.
            state_d    = S_SEND;
            tx_start_d = 1'b1;
            tx_data_d  = 8'h2B;
          end
        end
      end
      S_SEND: begin
        state_d = S_WAIT_TX;
        if (!tx_start_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = frame_byte(idx_q, cmd_q, addr_q, value_q);
        end
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          if (idx_q == frame_len(cmd_q) - 4'd1) begin
            state_d = S_RECV;
            cnt_d   = '0;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SEND;
          end
        end
      end
      S_RECV: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_done) begin
          cnt_d    = '0;
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd0) begin
            ok0_d = (rx_data == 8'h4F);
          end else if (rx_idx_q == 3'd1) begin
            if (ok0_q && rx_data == 8'h4B) begin
              rsp_ok_d = 1'b1;
              if (reply_len(cmd_q) == 3'd2) begin
                state_d     = S_DONE;
                rsp_valid_d = 1'b1;
              end
            end else begin
              rsp_ok_d    = 1'b0;
              state_d     = S_DONE;
              rsp_valid_d = 1'b1;
            end
          end else begin
            rsp_data_d = {rsp_data_q[23:0], rx_data};
            if (rx_idx_q == reply_len(cmd_q) - 3'd1) begin
              state_d     = S_DONE;
              rsp_valid_d = 1'b1;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          rsp_timeout_d = 1'b1;
          rsp_ok_d      = 1'b0;
          state_d       = S_DONE;
          rsp_valid_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_ok      = rsp_ok_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_data    = rsp_data_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;

endmodule

// File: tb/tb_debug_host.sv
// Scoreboard bench for debug_host: stimulus queues expected tx bytes and responses,
// a negedge monitor pops and compares whenever the DUT strobes tx_start or rsp_valid.
module tb_debug_host;
  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = 3'd0;
  logic [31:0] req_address = 32'd0;
  logic [31:0] req_value = 32'd0;
  logic        rsp_valid, rsp_ok, rsp_timeout;
  logic [31:0] rsp_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_done = 1'b0;

  debug_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_address(req_address), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_timeout(rsp_timeout), .rsp_data(rsp_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .rx_data(rx_data), .rx_done(rx_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       first;
  } tx_exp_t;

  typedef struct {
    logic        ok;
    logic        to;
    logic [31:0] data;
    int          cyc;
  } rsp_exp_t;

  tx_exp_t  exp_tx[$];
  rsp_exp_t exp_rsp[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int accept_cyc = 0;
  int last_done_cyc = 0;
  int last_rx_cyc = 0;
  int done_cnt = 0;
  logic [7:0] cur_tx = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h, required no event (cycle %0d)", name, act, cyc);
  endtask

  // Transmitter model: acknowledges each started byte 5 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat (5) @(posedge clk);
        #1 tx_done = 1'b1;
        done_cnt++;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // Monitor: compares every DUT strobe against the scoreboard heads.
  always @(negedge clk) begin
    tx_exp_t  e;
    rsp_exp_t r;
    if (tx_start) begin
      if (exp_tx.size() == 0) begin
        fail_evt("tx_unexpected", 32'(tx_data));
      end else begin
        e = exp_tx.pop_front();
        cur_tx = e.b;
        chk("tx_byte", 32'(tx_data), 32'(e.b));
        if (e.first) chk("tx_first_latency", 32'(cyc), 32'(accept_cyc + 1));
        else         chk("tx_gap", 32'(cyc), 32'(last_done_cyc + 2));
      end
    end
    if (tx_done) begin
      last_done_cyc = cyc;
      if (reset) chk("tx_data_hold", 32'(tx_data), 32'(cur_tx));
    end
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        fail_evt("rsp_unexpected", rsp_data);
      end else begin
        r = exp_rsp.pop_front();
        chk("rsp_ok", 32'(rsp_ok), 32'(r.ok));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(r.to));
        chk("rsp_data", rsp_data, r.data);
        chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
        chk("rsp_ready_low", 32'(req_ready), 32'd0);
      end
    end
  end

  task automatic exp_frame(input int n, input logic [87:0] bytes);
    tx_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b = bytes[8*(n-1-i) +: 8];
      e.first = (i == 0);
      exp_tx.push_back(e);
    end
  endtask

  task automatic exp_reply(input logic ok, input logic to, input logic [31:0] data, input int at);
    rsp_exp_t r;
    r.ok = ok;
    r.to = to;
    r.data = data;
    r.cyc = at;
    exp_rsp.push_back(r);
  endtask

  task automatic do_req(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] v);
    @(posedge clk);
    #1;
    req_cmd = cmd;
    req_address = a;
    req_value = v;
    req_valid = 1'b1;
    accept_cyc = cyc;
    if (cmd > 3'd5) exp_reply(1'b0, 1'b0, 32'd0, cyc + 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    last_rx_cyc = cyc;
    @(posedge clk);
    #1 rx_done = 1'b0;
  endtask

  task automatic wait_tx_dones(input int base, input int n);
    int g;
    g = 0;
    while (done_cnt < base + n && g < 500) begin
      @(posedge clk);
      g++;
    end
    if (done_cnt < base + n) chk("tx_done_wait", 32'(done_cnt), 32'(base + n));
  endtask

  task automatic wait_rsp();
    int g;
    g = 0;
    while (exp_rsp.size() != 0 && g < 400) begin
      @(posedge clk);
      g++;
    end
    if (exp_rsp.size() != 0) begin
      chk("rsp_wait", 32'(exp_rsp.size()), 32'd0);
      exp_rsp.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_ok"}, 32'(rsp_ok), 32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
  endtask

  initial begin
    int base;
    int k;

    // Power-on reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset_hold");
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_idle("reset_release");

    // Unsolicited byte in IDLE must be dropped.
    rx_byte(8'h4F);
    repeat (2) @(posedge clk);

    // HL.
    exp_frame(3, 88'h2B484C);
    base = done_cnt;
    do_req(3'd0, 32'd0, 32'd0);
    wait_tx_dones(base, 3);
    rx_byte(8'h4F);
    rx_byte(8'h4B);
    exp_reply(1'b1, 1'b0, 32'd0, last_rx_cyc + 1);
    wait_rsp();

    // MR with a busy-time request that must be ignored.
    exp_frame(7, 88'h2B4D5200001000);
    base = done_cnt;
    do_req(3'd4, 32'h0000_1000, 32'd0);
    #1;
    req_cmd = 3'd7;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_tx_dones(base, 7);
    rx_byte(8'h4F);
    rx_byte(8'h4B);
    rx_byte(8'hDE);
    rx_byte(8'hAD);
    rx_byte(8'hBE);
    rx_byte(8'hEF);
    exp_reply(1'b1, 1'b0, 32'hDEAD_BEEF, last_rx_cyc + 1);
    wait_rsp();

    // Reset in the middle of an MR frame: only two bytes leave, nothing after.
    exp_frame(7, 88'h2B4D5200001000);
    base = done_cnt;
    do_req(3'd4, 32'h0000_1000, 32'd0);
    wait_tx_dones(base, 2);
    #1;
    reset = 1'b0;
    exp_tx.delete();
    @(posedge clk);
    @(negedge clk);
    chk_idle("midreset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);

    // MW refused with "NO".
    exp_frame(11, 88'h2B4D57_00000010_12345678);
    base = done_cnt;
    do_req(3'd5, 32'h0000_0010, 32'h1234_5678);
    wait_tx_dones(base, 11);
    rx_byte(8'h4E);
    rx_byte(8'h4F);
    exp_reply(1'b0, 1'b0, 32'd0, last_rx_cyc + 1);
    wait_rsp();

    // ST.
    exp_frame(3, 88'h2B5354);
    base = done_cnt;
    do_req(3'd3, 32'd0, 32'd0);
    wait_tx_dones(base, 3);
    rx_byte(8'h4F);
    rx_byte(8'h4B);
    rx_byte(8'h52);
    exp_reply(1'b1, 1'b0, 32'h0000_0052, last_rx_cyc + 1);
    wait_rsp();

    // Invalid command: immediate refusal, no tx bytes, previous data cleared.
    do_req(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp();

    // PC timing out after "OK".
    exp_frame(3, 88'h2B5043);
    base = done_cnt;
    do_req(3'd2, 32'd0, 32'd0);
    wait_tx_dones(base, 3);
    rx_byte(8'h4F);
    rx_byte(8'h4B);
    exp_reply(1'b0, 1'b1, 32'd0, last_rx_cyc + TO + 1);
    wait_rsp();

    // PC with a byte landing exactly on the expiry cycle.
    exp_frame(3, 88'h2B5043);
    base = done_cnt;
    do_req(3'd2, 32'd0, 32'd0);
    wait_tx_dones(base, 3);
    rx_byte(8'h4F);
    rx_byte(8'h4B);
    k = last_rx_cyc;
    repeat (TO - 2) @(posedge clk);
    rx_byte(8'h11);
    chk("expiry_byte_cycle", 32'(last_rx_cyc), 32'(k + TO));
    rx_byte(8'h22);
    rx_byte(8'h33);
    rx_byte(8'h44);
    exp_reply(1'b1, 1'b0, 32'h1122_3344, last_rx_cyc + 1);
    wait_rsp();

    @(negedge clk);
    chk("final_ready", 32'(req_ready), 32'd1);
    chk("tx_leftover", 32'(exp_tx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end, required finish by 400000");
    $fatal(1, "watchdog");
  end

endmodule
